// File: rtl/assoc_search.sv
// Associative-memory search: chunk-serial Hamming distance of a query against two class vectors.
// Optional `ASSOC_MARGIN_EN adds a registered |dist_nonseizure - dist_seizure| output.
module assoc_search #(
  parameter int unsigned DIMENSIONS = 1024,
  parameter int unsigned CHUNK_SIZE = 64,
  parameter int unsigned DIST_SIZE  = $clog2(DIMENSIONS + 1)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [DIMENSIONS-1:0] hv_query,
  input  logic [DIMENSIONS-1:0] hv_nonseizure,
  input  logic [DIMENSIONS-1:0] hv_seizure,
  output logic                  busy,
  output logic                  done,
  output logic                  label,
  output logic [DIST_SIZE-1:0]  dist_nonseizure,
  output logic [DIST_SIZE-1:0]  dist_seizure
`ifdef ASSOC_MARGIN_EN
  ,
  output logic [DIST_SIZE-1:0]  margin
`endif
);

  localparam int unsigned NUM_CHUNKS = DIMENSIONS / CHUNK_SIZE;
  localparam int unsigned IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int unsigned PC_W       = $clog2(CHUNK_SIZE + 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic [DIST_SIZE-1:0]  acc_ns;
  logic [DIST_SIZE-1:0]  acc_sz;
  logic [DIMENSIONS-1:0] q_r;
  logic [DIMENSIONS-1:0] ns_r;
  logic [DIMENSIONS-1:0] sz_r;

  logic [CHUNK_SIZE-1:0] diff_ns_c;
  logic [CHUNK_SIZE-1:0] diff_sz_c;
  logic [PC_W-1:0]       pc_ns_c;
  logic [PC_W-1:0]       pc_sz_c;

  function automatic logic [PC_W-1:0] popcount(input logic [CHUNK_SIZE-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(CHUNK_SIZE); i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

  // Shared datapath: XOR and popcount of the current chunk for both classes
  always_comb begin
    diff_ns_c = q_r[int'(idx) * int'(CHUNK_SIZE) +: CHUNK_SIZE] ^
                ns_r[int'(idx) * int'(CHUNK_SIZE) +: CHUNK_SIZE];
    diff_sz_c = q_r[int'(idx) * int'(CHUNK_SIZE) +: CHUNK_SIZE] ^
                sz_r[int'(idx) * int'(CHUNK_SIZE) +: CHUNK_SIZE];
    pc_ns_c   = popcount(diff_ns_c);
    pc_sz_c   = popcount(diff_sz_c);
  end

  // Control FSM with registered outputs; busy stays high through the done cycle
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state           <= IDLE;
      idx             <= '0;
      acc_ns          <= '0;
      acc_sz          <= '0;
      q_r             <= '0;
      ns_r            <= '0;
      sz_r            <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      label           <= 1'b0;
      dist_nonseizure <= '0;
      dist_seizure    <= '0;
`ifdef ASSOC_MARGIN_EN
      margin          <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= en;
          if (en) begin
            q_r    <= hv_query;
            ns_r   <= hv_nonseizure;
            sz_r   <= hv_seizure;
            acc_ns <= '0;
            acc_sz <= '0;
            idx    <= '0;
            state  <= ACC;
          end
        end
        ACC: begin
          acc_ns <= acc_ns + DIST_SIZE'(pc_ns_c);
          acc_sz <= acc_sz + DIST_SIZE'(pc_sz_c);
          if (idx == IDX_W'(NUM_CHUNKS - 1)) begin
            state <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          dist_nonseizure <= acc_ns;
          dist_seizure    <= acc_sz;
          label           <= (acc_sz < acc_ns);
`ifdef ASSOC_MARGIN_EN
          margin          <= (acc_ns >= acc_sz) ? (acc_ns - acc_sz) : (acc_sz - acc_ns);
`endif
          done            <= 1'b1;
          busy            <= 1'b1;
          state           <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
